if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Producer side of the IF/ID pipeline register: owns the PC, issues requests to instruction memory,
//  buffers returned words in a small prefetch queue, presents {pc+4, instruction} to the IF/ID register.
//  Honours freeze from the hazard unit and redirects on taken branches from EXE, dropping wrong-path work.
// PARAMETERS
//  N         32   data/address width
//  DEPTH     2    prefetch queue entries (power of 2, >=2); bounds queued + outstanding fetches
//  RESET_PC  0    first fetch address after reset
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  freeze         in   1   hazard stall; IF/ID register holds, no pop
//  branch_taken   in   1   redirect pulse from EXE
//  branch_addr    in   N   redirect target
//  imem_req       out  1   fetch request valid
//  imem_addr      out  N   fetch address (word aligned)
//  imem_ready     in   1   memory accepts request when imem_req && imem_ready
//  imem_rvalid    in   1   in-order response valid, >=1 cycle after accept
//  imem_rdata     in   N   response word
//  valid_out      out  1   queue head valid
//  pc_out         out  N   head pc+4 (0 when !valid_out)
//  instruction    out  N   head word (0 = NOP bubble when !valid_out)
// BEHAVIOUR
//  - Reset (sync, highest priority): fetch_pc<=RESET_PC, queue empty, state IDLE; imem_req=0,
//    valid_out=0, pc_out=0, instruction=0. Responses with nothing outstanding are ignored.
//  - Exactly one outstanding request. FSM: IDLE -> WAIT on accept; WAIT -> IDLE on imem_rvalid;
//    WAIT -> DROP on branch_taken; DROP -> IDLE on imem_rvalid (response discarded).
//  - imem_req = (state==IDLE) && !branch_taken && (count < DEPTH); imem_addr = fetch_pc.
//  - Accept: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^N, wraps silently).
//  - Response in WAIT: push {req_pc+4, imem_rdata}. Credit check at issue guarantees no overflow.
//  - Pop when valid_out && !freeze; output combinational from queue head (zero when empty).
//  - Push and pop same cycle: both happen, count unchanged; on empty, pushed word appears next cycle
//    (fetch-to-output latency = memory latency + 1).
//  - branch_taken (beats freeze and everything else): queue flushed, fetch_pc<=branch_addr,
//    no request that cycle; WAIT->DROP; a response arriving the same cycle is discarded.
//    First target request issues next cycle if IDLE, else after the dropped response returns.
//  - freeze with full queue: issue stalls via credit; memory response still accepted if outstanding.
// CONFIGURATION
//  IF_FETCH_PERF_EN defined: extra outputs perf_fetches[31:0] (accepted requests),
//    perf_stall_cycles[31:0] (freeze && valid_out), perf_redirects[31:0] (branch_taken);
//    cleared on rst, saturate at all-ones.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package if_fetch_pkg: fetch_state_t {IDLE, WAIT, DROP}, PC_STEP=4, fetch_entry_t {pc, instr}.
//  Sub-module if_fetch_fifo: DEPTH-entry sync FIFO (push, pop, flush, count, head); flush beats push.
//  Top: PC/next-PC logic, FSM, credit check, optional perf counters.
// TESTING
//  1. rst, 1-cycle memory, freeze=0 -> addrs 0,4,8 issued; outputs pc_out=4,8,12 with matching words.
//  2. freeze held 5 cycles, DEPTH=2 -> queue fills to 2, imem_req drops; release -> 2 pops, fetch resumes.
//  3. branch_taken (addr 0x100) while WAIT, 3-cycle memory -> returning word dropped, valid_out=0,
//     next imem_addr=0x100, then pc_out=0x104.
//  4. branch_taken same cycle as imem_rvalid with freeze=1 -> word discarded, queue empty, redirect taken.
//  5. rst asserted mid-WAIT -> next cycle all outputs 0, late imem_rvalid ignored, imem_addr=RESET_PC.
//  6. fetch_pc=0xFFFFFFFC accepted -> next imem_addr=0x0; with IF_FETCH_PERF_EN counters match cycle counts.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_fetch_pkg;

    // Byte distance between consecutive instruction words
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        StIdle,   // free to issue a request
        StWait,   // one request outstanding, response will be queued
        StDrop    // one wrong-path request outstanding, response will be discarded
    } fetch_state_t;

    // 32-bit view of one prefetch queue entry
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit and memory.
interface if_fetch_unit_if #(
    parameter int unsigned N = 32
) ();

    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;

    // Fetch unit side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// Small synchronous prefetch FIFO; flush has priority over push and pop.
module if_fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage array, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: PC ownership, single-outstanding memory requests,
// prefetch queue feeding the IF/ID register, freeze and branch redirect handling.
// Optional performance counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter int unsigned   N        = 32,
    parameter int unsigned   DEPTH    = 2,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [N-1:0]     branch_addr,
    if_fetch_unit_if.master  imem,
    output logic             valid_out,
    output logic [N-1:0]     pc_out,
    output logic [N-1:0]     instruction
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetches,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_redirects
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_t  state_q;
    logic [N-1:0]  fetch_pc_q;
    logic [N-1:0]  req_pc_q;

    logic          credit;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [2*N-1:0] head;

    // Issue only when idle, not redirecting and the queue can absorb the response
    always_comb begin
        credit         = count < CW'(DEPTH);
        imem.imem_req  = !rst && (state_q == StIdle) && !branch_taken && credit;
        imem.imem_addr = fetch_pc_q;
        accept         = imem.imem_req && imem.imem_ready;
        push           = (state_q == StWait) && imem.imem_rvalid && !branch_taken;
        pop            = valid_out && !freeze;
    end

    // Request FSM and PC tracking; a redirect overrides everything but reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else if (branch_taken) begin
            fetch_pc_q <= branch_addr;
            // A response landing this cycle closes the outstanding request
            state_q    <= (state_q != StIdle && !imem.imem_rvalid) ? StDrop : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StWait;
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + N'(PC_STEP);
                    end
                end
                StWait, StDrop: begin
                    if (imem.imem_rvalid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    if_fetch_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_taken),
        .wdata ({req_pc_q + N'(PC_STEP), imem.imem_rdata}),
        .head  (head),
        .count (count)
    );

    // Head of queue drives the IF/ID register; zeros form a NOP bubble when empty
    always_comb begin
        valid_out   = count != '0;
        pc_out      = valid_out ? head[2*N-1:N] : '0;
        instruction = valid_out ? head[N-1:0]   : '0;
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetches_q;
    logic [31:0] stalls_q;
    logic [31:0] redirects_q;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fetches_q   <= '0;
            stalls_q    <= '0;
            redirects_q <= '0;
        end else begin
            if (accept && fetches_q != '1) begin
                fetches_q <= fetches_q + 1'b1;
            end
            if (freeze && valid_out && stalls_q != '1) begin
                stalls_q <= stalls_q + 1'b1;
            end
            if (branch_taken && redirects_q != '1) begin
                redirects_q <= redirects_q + 1'b1;
            end
        end
    end

    assign perf_fetches      = fetches_q;
    assign perf_stall_cycles = stalls_q;
    assign perf_redirects    = redirects_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a latency-configurable memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instruction;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    int errors = 0;
    int checks = 0;

    if_fetch_unit_if #(.N(32)) bus ();

    if_fetch_unit #(
        .N        (32),
        .DEPTH    (2),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus),
        .valid_out    (valid_out),
        .pc_out       (pc_out),
        .instruction  (instruction)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetches      (perf_fetches),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: response mem_lat cycles after accept, one cycle wide
    int          mem_lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    always @(posedge clk) begin
        bus.imem_rvalid <= 1'b0;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= word_of(mem_addr);
                mem_busy        <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
        if (bus.imem_req && bus.imem_ready) begin
            if (mem_lat <= 1) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= word_of(bus.imem_addr);
            end else begin
                mem_busy <= 1'b1;
                mem_cnt  <= mem_lat - 1;
                mem_addr <= bus.imem_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Holds reset long enough for any memory response to drain; returns in cycle 0
    task automatic do_reset();
        rst = 1'b1;
        branch_taken = 1'b0;
        freeze = 1'b0;
        bus.imem_ready = 1'b0;
        repeat (5) tick();
        bus.imem_ready = 1'b1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ready = 1'b1;
        repeat (2) tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (valid_out !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (pc_out !== 32'h0) begin errors++;
            $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
        checks++; if (instruction !== 32'h0) begin errors++;
            $display("FAIL reset_instr: got %h expected 0", instruction); end
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h expected 1/0",
                     bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_pc   [3] = '{32'h4, 32'h8, 32'hC};
        logic [31:0] iss [3];
        logic [31:0] pco [3];
        logic [31:0] ino [3];
        int n_iss = 0;
        int n_out = 0;
        int first_cyc = -1;
        mem_lat = 1;
        do_reset();
        for (int cyc = 0; cyc < 30 && n_out < 3; cyc++) begin
            if (bus.imem_req && bus.imem_ready && n_iss < 3) begin
                iss[n_iss] = bus.imem_addr;
                n_iss++;
            end
            if (valid_out) begin
                if (n_out == 0) first_cyc = cyc;
                pco[n_out] = pc_out;
                ino[n_out] = instruction;
                n_out++;
            end
            tick();
        end
        checks++; if (n_out !== 3 || n_iss !== 3) begin errors++;
            $display("FAIL seq_count: got out=%0d iss=%0d expected 3/3", n_out, n_iss); end
        checks++; if (first_cyc !== 2) begin errors++;
            $display("FAIL seq_latency: got cycle %0d expected 2", first_cyc); end
        for (int k = 0; k < 3; k++) begin
            if (k < n_iss) begin
                checks++; if (iss[k] !== exp_addr[k]) begin errors++;
                    $display("FAIL seq_addr%0d: got %h expected %h", k, iss[k], exp_addr[k]); end
            end
            if (k < n_out) begin
                checks++; if (pco[k] !== exp_pc[k] || ino[k] !== word_of(exp_addr[k])) begin
                    errors++;
                    $display("FAIL seq_out%0d: got %h/%h expected %h/%h", k, pco[k], ino[k],
                             exp_pc[k], word_of(exp_addr[k])); end
            end
        end
    endtask

    task automatic test_freeze();
        int n_acc = 0;
        mem_lat = 1;
        do_reset();
        freeze = 1'b1;
        repeat (6) begin
            if (bus.imem_req && bus.imem_ready) n_acc++;
            tick();
        end
        checks++; if (n_acc !== 2) begin errors++;
            $display("FAIL freeze_accepts: got %0d expected 2", n_acc); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL freeze_credit: got req=%b expected 0", bus.imem_req); end
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h4 || instruction !== word_of(32'h0))
            begin errors++;
            $display("FAIL freeze_hold: got %b/%h/%h expected 1/4/%h", valid_out, pc_out,
                     instruction, word_of(32'h0)); end
        freeze = 1'b0;
        tick();
        checks++; if (pc_out !== 32'h8 || instruction !== word_of(32'h4)) begin errors++;
            $display("FAIL freeze_pop2: got %h/%h expected 8/%h", pc_out, instruction,
                     word_of(32'h4)); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++;
            $display("FAIL freeze_resume: got req=%b addr=%h expected 1/8", bus.imem_req,
                     bus.imem_addr); end
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++;
            $display("FAIL freeze_drained: got %b expected 0", valid_out); end
        tick();
        checks++; if (pc_out !== 32'hC || instruction !== word_of(32'h8)) begin errors++;
            $display("FAIL freeze_next: got %h/%h expected c/%h", pc_out, instruction,
                     word_of(32'h8)); end
    endtask

    task automatic test_branch_wait();
        int n = 0;
        mem_lat = 3;
        do_reset();
        tick();
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++;
            $display("FAIL br_no_req: got %b expected 0", bus.imem_req); end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || valid_out !== 1'b0) begin errors++;
            $display("FAIL br_drop_wait: got req=%b valid=%b expected 0/0", bus.imem_req,
                     valid_out); end
        repeat (2) tick();
        checks++; if (valid_out !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100)
            begin errors++;
            $display("FAIL br_target_req: got valid=%b req=%b addr=%h expected 0/1/100",
                     valid_out, bus.imem_req, bus.imem_addr); end
        while (!valid_out && n < 12) begin
            tick();
            n++;
        end
        checks++; if (pc_out !== 32'h104 || instruction !== word_of(32'h100)) begin errors++;
            $display("FAIL br_target_out: got %h/%h expected 104/%h", pc_out, instruction,
                     word_of(32'h100)); end
    endtask

    task automatic test_branch_rvalid_freeze();
        int n = 0;
        mem_lat = 3;
        do_reset();
        freeze = 1'b1;
        while (!valid_out && n < 20) begin tick(); n++; end
        n = 0;
        while (!bus.imem_rvalid && n < 20) begin tick(); n++; end
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h4) begin errors++;
            $display("FAIL brf_pre: got valid=%b pc=%h expected 1/4", valid_out, pc_out); end
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction !== 32'h0) begin
            errors++;
            $display("FAIL brf_flushed: got %b/%h/%h expected 0/0/0", valid_out, pc_out,
                     instruction); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++;
            $display("FAIL brf_redirect: got req=%b addr=%h expected 1/200", bus.imem_req,
                     bus.imem_addr); end
        freeze = 1'b0;
        n = 0;
        while (!valid_out && n < 12) begin tick(); n++; end
        checks++; if (pc_out !== 32'h204 || instruction !== word_of(32'h200)) begin errors++;
            $display("FAIL brf_target_out: got %h/%h expected 204/%h", pc_out, instruction,
                     word_of(32'h200)); end
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        mem_lat = 3;
        do_reset();
        tick();
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b0 || valid_out !== 1'b0 || pc_out !== 32'h0 ||
                      instruction !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++;
            $display("FAIL rstw_outputs: got req=%b valid=%b pc=%h instr=%h addr=%h expected 0",
                     bus.imem_req, valid_out, pc_out, instruction, bus.imem_addr); end
        rst = 1'b0;
        #1;
        repeat (2) tick();
        checks++; if (valid_out !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0)
            begin errors++;
            $display("FAIL rstw_late_rsp: got valid=%b req=%b addr=%h expected 0/1/0",
                     valid_out, bus.imem_req, bus.imem_addr); end
        mem_lat = 1;
        bus.imem_ready = 1'b1;
        while (!valid_out && n < 12) begin tick(); n++; end
        checks++; if (pc_out !== 32'h4 || instruction !== word_of(32'h0)) begin errors++;
            $display("FAIL rstw_refetch: got %h/%h expected 4/%h", pc_out, instruction,
                     word_of(32'h0)); end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        do_reset();
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_req: got req=%b addr=%h expected 1/fffffffc", bus.imem_req,
                     bus.imem_addr); end
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++;
            $display("FAIL wrap_next_addr: got %h expected 0", bus.imem_addr); end
        tick();
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h0 ||
                      instruction !== word_of(32'hFFFF_FFFC)) begin errors++;
            $display("FAIL wrap_out: got %b/%h/%h expected 1/0/%h", valid_out, pc_out,
                     instruction, word_of(32'hFFFF_FFFC)); end
`ifdef IF_FETCH_PERF_EN
        checks++; if (perf_fetches !== 32'd1 || perf_redirects !== 32'd1 ||
                      perf_stall_cycles !== 32'd0) begin errors++;
            $display("FAIL perf_a: got f=%0d r=%0d s=%0d expected 1/1/0", perf_fetches,
                     perf_redirects, perf_stall_cycles); end
        freeze = 1'b1;
        repeat (2) tick();
        freeze = 1'b0;
        checks++; if (perf_fetches !== 32'd2 || perf_redirects !== 32'd1 ||
                      perf_stall_cycles !== 32'd2) begin errors++;
            $display("FAIL perf_b: got f=%0d r=%0d s=%0d expected 2/1/2", perf_fetches,
                     perf_redirects, perf_stall_cycles); end
`endif
    endtask

    initial begin
        bus.imem_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_freeze();
        test_branch_wait();
        test_branch_rvalid_freeze();
        test_reset_mid_wait();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
